tx_burst_ctrl: RTL and testbench

Sequencer and phase generator for the TX upconversion channel. It owns the 24-bit NCO phase accumulator that drives the channel's `phase_input` and applies CSR frequency updates on sample boundaries. It also gates the baseband I/Q stream into the upsamplers through a ramped burst state machine: ramp-up, on, ramp-down, idle. The block sits between the CSR/baseband source and the TX channel, in the `sys_clk` domain.

---
 rtl/tx_burst_if.sv | 32 +++
 rtl/tx_burst_ctrl.sv | 156 +++++++++++++++
 tb/tb_tx_burst_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tx_burst_if.sv
// Baseband, CSR and burst-control bundle between the TX source and tx_burst_ctrl.
interface tx_burst_if #(
  parameter int unsigned IW    = 16,
  parameter int unsigned PW_I  = 24,
  parameter int unsigned LEN_W = 16
);
  logic                    ce;
  logic signed [IW-1:0]    i_x;
  logic signed [IW-1:0]    i_y;
  logic [PW_I-1:0]         csr_ftw;
  logic                    csr_ftw_stb;
  logic                    start;
  logic                    stop;
  logic [LEN_W-1:0]        burst_len;
  logic signed [IW-1:0]    o_x;
  logic signed [IW-1:0]    o_y;
  logic                    o_ce;
  logic [PW_I-1:0]         phase_out;
  logic                    busy;
  logic                    done;
  logic [1:0]              state;

  modport master (
    output ce, i_x, i_y, csr_ftw, csr_ftw_stb, start, stop, burst_len,
    input  o_x, o_y, o_ce, phase_out, busy, done, state
  );

  modport slave (
    input  ce, i_x, i_y, csr_ftw, csr_ftw_stb, start, stop, burst_len,
    output o_x, o_y, o_ce, phase_out, busy, done, state
  );
endinterface

// File: rtl/tx_burst_ctrl.sv
// TX burst sequencer: NCO phase accumulator with sample-aligned FTW updates
// and a ramp-up / on / ramp-down gain envelope on the baseband I/Q stream.
module tx_burst_ctrl #(
  parameter int unsigned IW        = 16,
  parameter int unsigned PW_I      = 24,
  parameter int unsigned RAMP_LOG2 = 6,
  parameter int unsigned LEN_W     = 16
) (
  input logic        sys_clk,
  input logic        rst,
  tx_burst_if.slave  bus
);
  localparam int unsigned GW  = RAMP_LOG2 + 1;
  localparam int unsigned PRW = IW + RAMP_LOG2 + 1;
  localparam logic [GW-1:0] G_LAST = GW'((1 << RAMP_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t                state_q, state_nxt;
  logic [GW-1:0]         g_q, g_nxt;
  logic [LEN_W-1:0]      cnt_q, cnt_nxt;
  logic                  cont_q, cont_nxt;
  logic                  done_q, done_nxt;
  logic                  busy_q;
  logic [PW_I-1:0]       acc_q, ftw_act_q, ftw_pend_q;
  logic                  pend_q;
  logic                  apply_c;
  logic signed [IW-1:0]  o_x_q, o_y_q;
  logic                  o_ce_q;
  logic signed [PRW-1:0] prod_x_c, prod_y_c;

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; stop outranks a simultaneous ramp/count step
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_nxt = S_RAMP_UP;
      S_RAMP_UP:   if (bus.stop) state_nxt = S_RAMP_DOWN;
                   else if (bus.ce && g_q == G_LAST) state_nxt = S_ON;
      S_ON:        if (bus.stop) state_nxt = S_RAMP_DOWN;
                   else if (bus.ce && !cont_q && cnt_q == LEN_W'(1)) state_nxt = S_RAMP_DOWN;
      S_RAMP_DOWN: if (bus.ce && g_q <= GW'(1)) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Gain, burst counter and done pulse next values
  always_comb begin
    g_nxt    = g_q;
    cnt_nxt  = cnt_q;
    cont_nxt = cont_q;
    done_nxt = 1'b0;
    case (state_q)
      S_IDLE: g_nxt = '0;
      S_RAMP_UP: begin
        if (!bus.stop && bus.ce) begin
          g_nxt = g_q + GW'(1);
          if (g_q == G_LAST) begin
            cnt_nxt  = bus.burst_len;
            cont_nxt = (bus.burst_len == '0);
          end
        end
      end
      S_ON: if (!bus.stop && bus.ce && !cont_q) cnt_nxt = cnt_q - LEN_W'(1);
      S_RAMP_DOWN: begin
        if (bus.ce) begin
          if (g_q <= GW'(1)) begin
            g_nxt    = '0;
            done_nxt = 1'b1;
          end else begin
            g_nxt = g_q - GW'(1);
          end
        end
      end
      default: g_nxt = '0;
    endcase
  end

  // Envelope datapath registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      g_q    <= '0;
      cnt_q  <= '0;
      cont_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      g_q    <= g_nxt;
      cnt_q  <= cnt_nxt;
      cont_q <= cont_nxt;
      done_q <= done_nxt;
      busy_q <= (state_nxt != S_IDLE);
    end
  end

  // Pending FTW lands on a sample boundary, or immediately when idle
  assign apply_c = pend_q && (bus.ce || state_q == S_IDLE);

  // NCO: pending/active FTW and phase accumulator; each accepted burst starts at phase 0
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
      ftw_act_q  <= '0;
      acc_q      <= '0;
    end else begin
      if (bus.csr_ftw_stb) ftw_pend_q <= bus.csr_ftw;
      pend_q <= bus.csr_ftw_stb | (pend_q & ~apply_c);
      if (apply_c) ftw_act_q <= ftw_pend_q;
      if (state_q == S_IDLE && bus.start) acc_q <= '0;
      else                                acc_q <= acc_q + ftw_act_q;
    end
  end

  // Signed gain products; g is zero-extended so it stays non-negative
  always_comb begin
    prod_x_c = PRW'(bus.i_x) * PRW'($signed({1'b0, g_q}));
    prod_y_c = PRW'(bus.i_y) * PRW'($signed({1'b0, g_q}));
  end

  // Scaled I/Q output registers, forced to zero while idle
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      o_x_q  <= '0;
      o_y_q  <= '0;
      o_ce_q <= 1'b0;
    end else begin
      o_ce_q <= bus.ce;
      if (state_q == S_IDLE) begin
        o_x_q <= '0;
        o_y_q <= '0;
      end else if (bus.ce) begin
        o_x_q <= IW'(prod_x_c >>> RAMP_LOG2);
        o_y_q <= IW'(prod_y_c >>> RAMP_LOG2);
      end
    end
  end

  assign bus.o_x       = o_x_q;
  assign bus.o_y       = o_y_q;
  assign bus.o_ce      = o_ce_q;
  assign bus.phase_out = acc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Directed bench for tx_burst_ctrl: reset, NCO stepping/wrap, full burst,
// continuous burst, early stop, sample-aligned FTW update, reset mid-burst.
module tb_tx_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tx_burst_if #(.IW(16), .PW_I(24), .LEN_W(16)) bus ();

  tx_burst_ctrl #(.IW(16), .PW_I(24), .RAMP_LOG2(6), .LEN_W(16)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dphase(input int now, input int prev);
    return (now - prev) & 32'h00FF_FFFF;
  endfunction

  initial begin
    int p;
    int g;
    int cnt;
    int st_exp;

    bus.ce = 1'b0; bus.i_x = '0; bus.i_y = '0;
    bus.csr_ftw = '0; bus.csr_ftw_stb = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.burst_len = '0;

    // Reset values
    #1 rst = 1'b1;
    tick(); tick();
    check("rst_o_x", bus.o_x, 0);
    check("rst_o_y", bus.o_y, 0);
    check("rst_o_ce", bus.o_ce, 0);
    check("rst_phase", bus.phase_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", bus.state, 0);
    rst = 1'b0;
    tick();

    // NCO: FTW 0x010000 while idle, then wrap, then double the step
    bus.csr_ftw = 24'h010000; bus.csr_ftw_stb = 1'b1;
    tick(); bus.csr_ftw_stb = 1'b0;
    tick();
    check("ftw_latency", bus.phase_out, 0);
    tick();
    check("ftw_first_step", bus.phase_out, 'h010000);
    for (int i = 0; i < 127; i++) tick();
    check("phase_half", bus.phase_out, 'h800000);
    for (int i = 0; i < 128; i++) tick();
    check("phase_wrap", bus.phase_out, 0);
    bus.csr_ftw = 24'h020000; bus.csr_ftw_stb = 1'b1;
    tick(); bus.csr_ftw_stb = 1'b0;
    check("ftw2_f1", bus.phase_out, 'h010000);
    tick();
    check("ftw2_f2", bus.phase_out, 'h020000);
    tick();
    check("ftw2_f3", bus.phase_out, 'h040000);
    tick();
    check("ftw2_f4", bus.phase_out, 'h060000);

    // Full burst: burst_len=10, ce every clock, full-scale I/Q
    bus.i_x = 16'sd32767; bus.i_y = -16'sd32768; bus.burst_len = 16'd10;
    bus.start = 1'b1; bus.ce = 1'b1;
    tick(); bus.start = 1'b0;
    check("burst_busy", bus.busy, 1);
    check("burst_state", bus.state, 1);
    check("burst_phase0", bus.phase_out, 0);
    for (int n = 0; n < 138; n++) begin
      tick();
      g = (n < 64) ? n : (n < 74) ? 64 : 138 - n;
      st_exp = (n < 63) ? 1 : (n < 73) ? 2 : (n < 137) ? 3 : 0;
      check("burst_o_x", bus.o_x, (32767 * g) >>> 6);
      check("burst_o_y", bus.o_y, (-32768 * g) >>> 6);
      check("burst_state", bus.state, st_exp);
      check("burst_done", bus.done, (n == 137) ? 1 : 0);
    end
    tick();
    check("post_o_x", bus.o_x, 0);
    check("post_done", bus.done, 0);
    check("post_busy", bus.busy, 0);

    // Continuous burst: burst_len=0 stays ON until stop
    bus.i_x = -16'sd12345; bus.burst_len = '0; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    check("cont_on", bus.state, 2);
    for (int i = 0; i < 1000; i++) tick();
    check("cont_still_on", bus.state, 2);
    check("cont_passthru", bus.o_x, -12345);
    check("cont_busy", bus.busy, 1);
    bus.stop = 1'b1;
    tick(); bus.stop = 1'b0;
    check("cont_stop", bus.state, 3);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); cnt++;
      if (bus.done) break;
    end
    check("cont_rampdown_len", cnt, 64);

    // Stop during ramp-up at g=20; start during ramp-down is ignored
    bus.i_x = 16'sd32767; bus.burst_len = 16'd5; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("early_o_x_g19", bus.o_x, (32767 * 19) >>> 6);
    bus.stop = 1'b1;
    tick(); bus.stop = 1'b0;
    check("early_state", bus.state, 3);
    check("early_o_x_g20", bus.o_x, 10239);
    bus.start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); cnt++; bus.start = 1'b0;
      if (i == 0) check("early_first_down", bus.o_x, 10239);
      if (bus.done) break;
    end
    check("early_down_len", cnt, 20);
    tick();
    check("early_idle", bus.state, 0);
    check("early_not_busy", bus.busy, 0);

    // FTW strobes between sparse ce pulses; last strobe applies on the ce edge
    bus.ce = 1'b0; bus.burst_len = '0; bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    bus.csr_ftw = 24'h000100; bus.csr_ftw_stb = 1'b1;
    p = bus.phase_out; tick(); bus.csr_ftw_stb = 1'b0;
    check("ftw_pre", dphase(bus.phase_out, p), 'h020000);
    p = bus.phase_out; tick();
    check("ftw_no_ce", dphase(bus.phase_out, p), 'h020000);
    bus.csr_ftw = 24'h000300; bus.csr_ftw_stb = 1'b1;
    p = bus.phase_out; tick(); bus.csr_ftw_stb = 1'b0;
    check("ftw_second_stb", dphase(bus.phase_out, p), 'h020000);
    bus.ce = 1'b1;
    p = bus.phase_out; tick(); bus.ce = 1'b0;
    check("ftw_ce_edge", dphase(bus.phase_out, p), 'h020000);
    p = bus.phase_out; tick();
    check("ftw_last_wins", dphase(bus.phase_out, p), 'h000300);
    p = bus.phase_out; tick();
    check("ftw_hold_new", dphase(bus.phase_out, p), 'h000300);

    // Reset mid-ON with i_x=1000
    bus.ce = 1'b1; bus.i_x = 16'sd1000; bus.i_y = -16'sd1000;
    cnt = 0;
    while (bus.state != 2'd2 && cnt < 100) begin
      tick(); cnt++;
    end
    check("reach_on", bus.state, 2);
    tick(); tick();
    check("on_o_x", bus.o_x, 1000);
    check("on_o_y", bus.o_y, -1000);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_o_x", bus.o_x, 0);
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_phase", bus.phase_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    tick(); tick();
    check("rst_hold_done", bus.done, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_phase", bus.phase_out, 0);
    check("post_rst_state", bus.state, 0);
    check("post_rst_done", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
